// File: rtl/pointdbl_pkg.sv
// Shared types and constants for the GF(2^4) Lopez-Dahab point-doubling engine.
// Field is GF(2^4) reduced by x^4+x+1; squaring is a fixed XOR network.
package pointdbl_pkg;

   localparam int                 FIELD_W   = 4;
   localparam logic [FIELD_W:0]   POLY      = 5'b10011;
   localparam logic [FIELD_W-1:0] A_DEFAULT = 4'h4;
   localparam logic [FIELD_W-1:0] B_DEFAULT = 4'h1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_M1,
      S_M2,
      S_M3,
      S_M4,
      S_M5,
      S_DONE
   } state_t;

   // a^2 mod x^4+x+1: x^4 folds to x+1, x^6 folds to x^3+x^2
   function automatic logic [FIELD_W-1:0] gf_sq(input logic [FIELD_W-1:0] a);
      return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
   endfunction

endpackage

// File: rtl/gf16_mul.sv
// Combinational GF(2^4) multiplier: carry-less product followed by reduction
// modulo x^4+x+1, so the result is always a fully reduced 4-bit element.
module gf16_mul
   import pointdbl_pkg::*;
(
   input  logic [FIELD_W-1:0] a,
   input  logic [FIELD_W-1:0] b,
   output logic [FIELD_W-1:0] p
);

   logic [2*FIELD_W-2:0] acc;

   // NOTE: every variable driven here is given a value before any branch, so no latch is inferred.
   always_comb begin
      acc = '0;
      for (int i = 0; i < FIELD_W; i++) begin
         if (b[i]) acc = acc ^ ({{(FIELD_W-1){1'b0}}, a} << i);
      end
      // Fold the high terms from the top down so each fold sees the earlier ones
      for (int i = 2*FIELD_W-2; i >= FIELD_W; i--) begin
         if (acc[i]) acc = acc ^ ({{(FIELD_W-2){1'b0}}, POLY} << (i - FIELD_W));
      end
      p = acc[FIELD_W-1:0];
   end

endmodule

// File: rtl/point_double_seq.sv
// Multi-cycle Lopez-Dahab doubler over GF(2^4): computes 2^k*P with one shared multiplier.
// Optional macro POINTDBL_EARLY_EXIT_EN stops iterating once the point reaches infinity (Z=0).
module point_double_seq
   import pointdbl_pkg::*;
#(
   parameter logic [FIELD_W-1:0] A_CONST = A_DEFAULT,
   parameter logic [FIELD_W-1:0] B_CONST = B_DEFAULT,
   parameter int                 ITER_W  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FIELD_W-1:0]  x_in,
   input  logic [FIELD_W-1:0]  y_in,
   input  logic [FIELD_W-1:0]  z_in,
   input  logic [ITER_W-1:0]   k_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FIELD_W-1:0]  x_out,
   output logic [FIELD_W-1:0]  y_out,
   output logic [FIELD_W-1:0]  z_out,
   output logic                busy
);

   localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

   state_t state, state_nxt;

   logic [FIELD_W-1:0] wx, wy, wz;
   logic [ITER_W-1:0]  cnt;
   logic [FIELD_W-1:0] t_z2, t_bz, t_az, t_f;

   logic [FIELD_W-1:0] z1s, x1s, y1s, z1q, x1q;
   logic [FIELD_W-1:0] x2, p_sum, wy_new;
   logic [FIELD_W-1:0] op_a, op_b, prod;
   logic               last_iter;

   assign z1s = gf_sq(wz);
   assign x1s = gf_sq(wx);
   assign y1s = gf_sq(wy);
   assign z1q = gf_sq(z1s);
   assign x1q = gf_sq(x1s);

   assign x2     = x1q ^ t_bz;
   assign p_sum  = t_az ^ y1s ^ t_bz;
   assign wy_new = t_f ^ prod;

`ifdef POINTDBL_EARLY_EXIT_EN
   // The new Z at the M5 commit is t_z2; Z=0 is the point at infinity, a fixed point
   assign last_iter = (cnt == CNT_ONE) || (t_z2 == '0);
`else
   assign last_iter = (cnt == CNT_ONE);
`endif

   gf16_mul u_mul (
      .a (op_a),
      .b (op_b),
      .p (prod)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_valid) state_nxt = (k_in == '0) ? S_DONE : S_M1;
         S_M1:   state_nxt = S_M2;
         S_M2:   state_nxt = S_M3;
         S_M3:   state_nxt = S_M4;
         S_M4:   state_nxt = S_M5;
         S_M5:   state_nxt = last_iter ? S_DONE : S_M1;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
      busy      = (state != S_IDLE);
      op_a      = '0;
      op_b      = '0;
      case (state)
         S_M1: begin op_a = z1s;     op_b = x1s;   end
         S_M2: begin op_a = B_CONST; op_b = z1q;   end
         S_M3: begin op_a = A_CONST; op_b = t_z2;  end
         S_M4: begin op_a = t_bz;    op_b = t_z2;  end
         S_M5: begin op_a = x2;      op_b = p_sum; end
         default: ;
      endcase
   end

   // The result copies load only on the edge that enters DONE, so they hold while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wx    <= '0;
         wy    <= '0;
         wz    <= '0;
         cnt   <= '0;
         t_z2  <= '0;
         t_bz  <= '0;
         t_az  <= '0;
         t_f   <= '0;
         x_out <= '0;
         y_out <= '0;
         z_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  wx  <= x_in;
                  wy  <= y_in;
                  wz  <= z_in;
                  cnt <= k_in;
                  if (k_in == '0) begin
                     x_out <= x_in;
                     y_out <= y_in;
                     z_out <= z_in;
                  end
               end
            end
            S_M1: t_z2 <= prod;
            S_M2: t_bz <= prod;
            S_M3: t_az <= prod;
            S_M4: t_f  <= prod;
            S_M5: begin
               wx  <= x2;
               wy  <= wy_new;
               wz  <= t_z2;
               cnt <= cnt - CNT_ONE;
               if (last_iter) begin
                  x_out <= x2;
                  y_out <= wy_new;
                  z_out <= t_z2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
